// File: rtl/multicycle_add_sub_if.sv
// Operand/result handshake bundle for the chunk-serial adder.
// slave = adder side, master = ALU operand/writeback side.
interface multicycle_add_sub_if #(
   parameter int WIDTH = 32
) ();
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_cin;
   logic             i_sub;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_sum;
   logic             o_cout;
   logic             o_ovf;
   logic             o_zero;

   modport slave (
      input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
      output o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero
   );

   modport master (
      output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
      input  o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero
   );
endinterface

// File: rtl/multicycle_add_sub.sv
// Chunk-serial add/subtract: CHUNK bits per clock through a
// registered carry, result and flags held until consumed.
module multicycle_add_sub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_add_sub_if.slave  bus
);
   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   generate
      if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
         $error("multicycle_add_sub: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_nxt;
   logic [WIDTH-1:0] sum_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic             ready_q;
   logic             valid_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   logic [CHUNK-1:0] a_c;
   logic [CHUNK-1:0] b_c;
   logic [CHUNK-1:0] s_c;
   logic             c_out;
   logic             c_msb;
   logic             last;

   always_comb begin
      a_c = a_q[idx_q*CHUNK +: CHUNK];
      b_c = b_q[idx_q*CHUNK +: CHUNK];
      {c_out, s_c} = {1'b0, a_c} + {1'b0, b_c}
                   + {{CHUNK{1'b0}}, carry_q};
      // carry into the chunk's top bit, recovered from its sum bit
      c_msb = s_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
      res_nxt = res_q;
      res_nxt[idx_q*CHUNK +: CHUNK] = s_c;
      last = (idx_q == IW'(NUM_CHUNKS - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  a_q     <= bus.i_a;
                  b_q     <= bus.i_sub ? ~bus.i_b : bus.i_b;
                  carry_q <= bus.i_sub ^ bus.i_cin;
                  idx_q   <= '0;
                  ready_q <= 1'b0;
                  state   <= RUN;
               end
            end
            RUN: begin
               res_q   <= res_nxt;
               carry_q <= c_out;
               idx_q   <= idx_q + 1'b1;
               if (last) begin
                  sum_q   <= res_nxt;
                  cout_q  <= c_out;
                  ovf_q   <= c_msb ^ c_out;
                  zero_q  <= (res_nxt == '0);
                  valid_q <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (bus.i_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_ready = ready_q;
   assign bus.o_valid = valid_q;
   assign bus.o_sum   = sum_q;
   assign bus.o_cout  = cout_q;
   assign bus.o_ovf   = ovf_q;
   assign bus.o_zero  = zero_q;
endmodule

// File: tb/tb_multicycle_add_sub.sv
// Directed vectors on the 32/8 config plus an exhaustive
// sweep of a 4/1 instance against an integer reference.
module tb_multicycle_add_sub;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_add_sub_if #(.WIDTH(32)) b32 ();
   multicycle_add_sub_if #(.WIDTH(4))  b4 ();

   multicycle_add_sub #(.WIDTH(32), .CHUNK(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (b32)
   );

   multicycle_add_sub #(.WIDTH(4), .CHUNK(1)) dut4 (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (b4)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } vec_t;

   vec_t vt[10];

   task automatic start32(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
      b32.i_a = a;
      b32.i_b = b;
      b32.i_cin = cin;
      b32.i_sub = sub;
      b32.i_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b32.i_valid = 1'b0;
   endtask

   task automatic wait32(output int lat);
      lat = 0;
      while (!b32.o_valid && lat < 50) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume32;
      b32.i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b32.i_ready = 1'b0;
   endtask

   task automatic start4(input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic sub);
      b4.i_a = a;
      b4.i_b = b;
      b4.i_cin = cin;
      b4.i_sub = sub;
      b4.i_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b4.i_valid = 1'b0;
   endtask

   task automatic wait4(output int lat);
      lat = 0;
      while (!b4.o_valid && lat < 50) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume4;
      b4.i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b4.i_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      logic seen;

      vt[0] = '{32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1};
      vt[1] = '{32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0};
      vt[2] = '{32'h7FFFFFFF, 32'h00000000, 1, 0, 32'h80000000, 0, 1, 0};
      vt[3] = '{32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0, 0};
      vt[4] = '{32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0};
      vt[5] = '{32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0, 0};
      vt[6] = '{32'h00001234, 32'h00001234, 0, 1, 32'h00000000, 1, 0, 1};
      vt[7] = '{32'h0000000A, 32'h00000003, 1, 1, 32'h00000006, 1, 0, 0};
      vt[8] = '{32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0, 0};
      vt[9] = '{32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1};

      b32.i_valid = 0; b32.i_ready = 0; b32.i_a = 0;
      b32.i_b = 0; b32.i_cin = 0; b32.i_sub = 0;
      b4.i_valid = 0; b4.i_ready = 0; b4.i_a = 0;
      b4.i_b = 0; b4.i_cin = 0; b4.i_sub = 0;

      repeat (2) @(negedge clk);
      chk("rst_ready", b32.o_ready, 1);
      chk("rst_valid", b32.o_valid, 0);
      chk("rst_sum", b32.o_sum, 0);
      chk("rst_flags", {b32.o_cout, b32.o_ovf, b32.o_zero}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         start32(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
         wait32(lat);
         chk($sformatf("v%0d_lat", i), lat, 4);
         chk($sformatf("v%0d_sum", i), b32.o_sum, vt[i].sum);
         chk($sformatf("v%0d_flags", i),
             {b32.o_cout, b32.o_ovf, b32.o_zero},
             {vt[i].cout, vt[i].ovf, vt[i].zero});
         consume32;
         chk($sformatf("v%0d_hs", i), {b32.o_ready, b32.o_valid}, 2'b10);
         chk($sformatf("v%0d_hold", i), b32.o_sum, vt[i].sum);
      end

      repeat (3) @(negedge clk);
      chk("idle_novalid", {b32.o_ready, b32.o_valid}, 2'b10);

      start32(32'h00FF00FF, 32'h0F0F0F0F, 0, 0);
      wait32(lat);
      chk("bp_lat", lat, 4);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("bp_hold%0d", i),
             {b32.o_valid, b32.o_ready, b32.o_sum},
             {1'b1, 1'b0, 32'h100E100E});
      end
      consume32;
      chk("bp_release", {b32.o_ready, b32.o_valid}, 2'b10);

      start32(32'h11111111, 32'h22222222, 0, 0);
      for (int i = 0; i < 3; i++) begin
         b32.i_a = $urandom;
         b32.i_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      b32.i_valid = 1'b0;
      wait32(lat);
      chk("tog_lat", lat, 1);
      chk("tog_sum", b32.o_sum, 32'h33333333);
      consume32;

      start32(32'hDEADBEEF, 32'h01010101, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_hs", {b32.o_ready, b32.o_valid}, 2'b10);
      chk("mid_rst_sum", b32.o_sum, 0);
      chk("mid_rst_flags", {b32.o_cout, b32.o_ovf, b32.o_zero}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (b32.o_valid) seen = 1'b1;
      end
      chk("mid_rst_nopulse", seen, 0);
      start32(32'h12345678, 32'h11111111, 0, 0);
      wait32(lat);
      chk("post_rst_lat", lat, 4);
      chk("post_rst_sum", b32.o_sum, 32'h23456789);
      consume32;

      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               for (int c = 0; c < 2; c++) begin
                  int sa, sb, r, full;
                  logic [3:0] es;
                  logic ec, eo;
                  sa = (a >= 8) ? a - 16 : a;
                  sb = (b >= 8) ? b - 16 : b;
                  if (s == 1) begin
                     full = a - b - c;
                     ec = (a >= b + c);
                     r = sa - sb - c;
                  end else begin
                     full = a + b + c;
                     ec = (full >= 16);
                     r = sa + sb + c;
                  end
                  es = 4'(full & 15);
                  eo = (r < -8) || (r > 7);
                  start4(4'(a), 4'(b), c[0], s[0]);
                  wait4(lat);
                  chk($sformatf("x4 s%0d a%0d b%0d c%0d", s, a, b, c),
                      {lat[7:0], b4.o_sum, b4.o_cout, b4.o_ovf,
                       b4.o_zero},
                      {8'd4, es, ec, eo, (es == 4'd0)});
                  consume4;
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
